// File: rtl/defines.sv
// ---------------------------------------------------------------------------
// defines
// Shared constant encodings for the instruction-memory subsystem.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package defines;

    // RV32I canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/type_pkg.sv
// ---------------------------------------------------------------------------
// type_pkg
// Bus types and loader state encoding for the instruction-memory loader.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package type_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } imem_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_bram.sv
// ---------------------------------------------------------------------------
// imem_bram
// Instruction memory built from four byte-wide banks: byte-granular write
// port and a word-wide synchronous read port. Contents are never reset.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module imem_bram #(
    parameter int DEPTH_BYTES = 256
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [$clog2(DEPTH_BYTES)-1:0]   waddr,
    input  logic [7:0]                       wdata,
    input  logic                             re,
    input  logic [$clog2(DEPTH_BYTES)-3:0]   raddr,
    output logic [31:0]                      rdata
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;

    // Byte lane b of every word lives in bank b, so a word read touches
    // one row in each bank and the result is naturally little-endian.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] mem [WORDS];
        logic [7:0] q;

        // Write the addressed lane; read one row per bank when enabled
        always_ff @(posedge clk) begin
            if (we && (waddr[1:0] == 2'(b))) begin
                mem[waddr[AW-1:2]] <= wdata;
            end
            if (re) begin
                q <= mem[raddr];
            end
        end
    end

    assign rdata = {g_bank[3].q, g_bank[2].q, g_bank[1].q, g_bank[0].q};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot loader and fetch port for the instruction memory. A byte stream is
// written into memory while the core is held off, then single-cycle word
// fetches are served with range and alignment checking.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module imem_loader
    import type_pkg::*;
    import defines::*;
#(
    parameter int          DEPTH_BYTES = 256,
    parameter logic [31:0] NOP_INST    = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_start_i,
    input  logic [15:0] ld_len_i,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ready_o,
    output logic        ld_done_o,
    input  logic        fetch_req_i,
    input  InstAddrBus  pc_i,
    output logic        fetch_valid_o,
    output InstBus      inst_o,
    output logic        fetch_err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_BYTES);

    imem_state_e state;
    logic [15:0] byte_cnt;
    logic [15:0] load_len;
    logic        accept;
    logic        last_byte;
    logic        fetch_acc;
    logic        pc_err;
    logic [31:0] rdata;

    assign accept    = ld_valid_i && ld_ready_o;
    assign last_byte = (byte_cnt == (load_len - 16'd1));
    // A load start in S_RUN wins and swallows a same-cycle fetch
    assign fetch_acc = (state == S_RUN) && fetch_req_i && !ld_start_i;
    assign pc_err    = (pc_i[1:0] != 2'b00) ||
                       (pc_i > InstAddrBus'(DEPTH_BYTES - 4));

    // Counter wraps modulo the memory size simply by dropping upper bits
    imem_bram #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_bram (
        .clk   (clk),
        .we    (accept),
        .waddr (byte_cnt[AW-1:0]),
        .wdata (ld_data_i),
        .re    (fetch_acc),
        .raddr (pc_i[AW-1:2]),
        .rdata (rdata)
    );

    // Faulting or idle slots always present the NOP word
    assign inst_o = (fetch_valid_o && !fetch_err_o) ? rdata : NOP_INST;

    // Loader FSM with registered handshake, status and fetch-response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_HALT;
            byte_cnt      <= '0;
            load_len      <= '0;
            ld_ready_o    <= 1'b0;
            ld_done_o     <= 1'b0;
            busy_o        <= 1'b1;
            fetch_valid_o <= 1'b0;
            fetch_err_o   <= 1'b0;
        end else begin
            ld_done_o     <= 1'b0;
            fetch_valid_o <= fetch_acc;
            fetch_err_o   <= fetch_acc && pc_err;
            case (state)
                S_HALT, S_RUN: begin
                    if (ld_start_i) begin
                        byte_cnt <= '0;
                        load_len <= ld_len_i;
                        if (ld_len_i != 16'd0) begin
                            state      <= S_LOAD;
                            ld_ready_o <= 1'b1;
                            busy_o     <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            ld_done_o <= 1'b1;
                            busy_o    <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (last_byte) begin
                            state      <= S_RUN;
                            ld_ready_o <= 1'b0;
                            ld_done_o  <= 1'b1;
                            busy_o     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= S_HALT;
                    ld_ready_o <= 1'b0;
                    busy_o     <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed testbench for imem_loader: a 256-byte instance for load, fetch,
// reload and reset behaviour, and an 8-byte instance for address wrap.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;
    import type_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 256-byte instance
    logic        ld_start = 1'b0;
    logic [15:0] ld_len = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, ld_done, fetch_valid, fetch_err, busy;
    logic        fetch_req = 1'b0;
    InstAddrBus  pc = '0;
    InstBus      inst;

    // 8-byte instance
    logic        b_ld_start = 1'b0;
    logic [15:0] b_ld_len = '0;
    logic        b_ld_valid = 1'b0;
    logic [7:0]  b_ld_data = '0;
    logic        b_ld_ready, b_ld_done, b_fetch_valid, b_fetch_err, b_busy;
    logic        b_fetch_req = 1'b0;
    InstAddrBus  b_pc = '0;
    InstBus      b_inst;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] bytes_q [16];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_BYTES(256)) u_dut (
        .clk (clk), .rst_n (rst_n),
        .ld_start_i (ld_start), .ld_len_i (ld_len),
        .ld_valid_i (ld_valid), .ld_data_i (ld_data),
        .ld_ready_o (ld_ready), .ld_done_o (ld_done),
        .fetch_req_i (fetch_req), .pc_i (pc),
        .fetch_valid_o (fetch_valid), .inst_o (inst),
        .fetch_err_o (fetch_err), .busy_o (busy)
    );

    imem_loader #(.DEPTH_BYTES(8)) u_dut8 (
        .clk (clk), .rst_n (rst_n),
        .ld_start_i (b_ld_start), .ld_len_i (b_ld_len),
        .ld_valid_i (b_ld_valid), .ld_data_i (b_ld_data),
        .ld_ready_o (b_ld_ready), .ld_done_o (b_ld_done),
        .fetch_req_i (b_fetch_req), .pc_i (b_pc),
        .fetch_valid_o (b_fetch_valid), .inst_o (b_inst),
        .fetch_err_o (b_fetch_err), .busy_o (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse ld_start for one cycle
    task automatic start_load(input logic [15:0] len);
        ld_start = 1'b1;
        ld_len   = len;
        @(negedge clk);
        ld_start = 1'b0;
        if (len != 16'd0) begin
            check("ready_after_start", 32'(ld_ready), 32'd1);
        end else begin
            check("done_len0", 32'(ld_done), 32'd1);
            check("busy_len0", 32'(busy), 32'd0);
        end
    endtask

    // Stream bytes_q[0..n-1], optionally with a 1,0,0,1 valid pattern
    task automatic feed(input int n, input bit gaps, input bit expect_done);
        int i = 0;
        int k = 0;
        logic v;
        while (i < n && k < 100) begin
            v = !gaps || (k % 4 == 0) || (k % 4 == 3);
            ld_valid = v;
            ld_data  = bytes_q[i];
            @(negedge clk);
            if (v) i++;
            k++;
            if (gaps && i < n) check("busy_hold", 32'(busy), 32'd1);
        end
        ld_valid = 1'b0;
        if (expect_done) begin
            check("done_pulse", 32'(ld_done), 32'd1);
            check("busy_fall", 32'(busy), 32'd0);
            check("ready_low", 32'(ld_ready), 32'd0);
            @(negedge clk);
            check("done_one_cycle", 32'(ld_done), 32'd0);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input logic exp_err,
                         input bit chk_inst);
        fetch_req = 1'b1;
        pc        = addr;
        @(negedge clk);
        fetch_req = 1'b0;
        check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        check({tag, "_err"}, 32'(fetch_err), 32'(exp_err));
        if (chk_inst) check({tag, "_inst"}, inst, exp_inst);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_fvalid", 32'(fetch_valid), 32'd0);
        check("rst_ferr", 32'(fetch_err), 32'd0);
        check("rst_inst", inst, NOP);
        check("rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load of two instructions
        bytes_q[0] = 8'h13; bytes_q[1] = 8'h00; bytes_q[2] = 8'h00; bytes_q[3] = 8'h00;
        bytes_q[4] = 8'h93; bytes_q[5] = 8'h00; bytes_q[6] = 8'hF0; bytes_q[7] = 8'h00;
        start_load(16'd8);
        feed(8, 1'b0, 1'b1);
        fetch("f_pc0", 32'd0, 32'h0000_0013, 1'b0, 1'b1);
        fetch("f_pc4", 32'd4, 32'h00F0_0093, 1'b0, 1'b1);

        // Back-to-back requests
        fetch_req = 1'b1; pc = 32'd4;
        @(negedge clk);
        pc = 32'd0;
        check("b2b_v0", 32'(fetch_valid), 32'd1);
        check("b2b_i0", inst, 32'h00F0_0093);
        @(negedge clk);
        fetch_req = 1'b0;
        check("b2b_v1", 32'(fetch_valid), 32'd1);
        check("b2b_i1", inst, 32'h0000_0013);
        @(negedge clk);
        check("idle_valid", 32'(fetch_valid), 32'd0);
        check("idle_err", 32'(fetch_err), 32'd0);
        check("idle_inst", inst, NOP);

        // Alignment and range faults
        fetch("mis2", 32'd2, NOP, 1'b1, 1'b1);
        fetch("top252", 32'd252, 32'd0, 1'b0, 1'b0);
        fetch("over256", 32'd256, NOP, 1'b1, 1'b1);
        fetch("mis253", 32'd253, NOP, 1'b1, 1'b1);

        // Gapped load of six bytes leaves bytes 6 and 7 untouched
        bytes_q[0] = 8'h11; bytes_q[1] = 8'h22; bytes_q[2] = 8'h33;
        bytes_q[3] = 8'h44; bytes_q[4] = 8'h55; bytes_q[5] = 8'h66;
        start_load(16'd6);
        feed(6, 1'b1, 1'b1);
        fetch("gap_pc0", 32'd0, 32'h4433_2211, 1'b0, 1'b1);
        fetch("gap_pc4", 32'd4, 32'h00F0_6655, 1'b0, 1'b1);

        // Reload wins over a same-cycle fetch
        ld_start = 1'b1; ld_len = 16'd4; fetch_req = 1'b1; pc = 32'd0;
        @(negedge clk);
        ld_start = 1'b0; fetch_req = 1'b0;
        check("reload_nofetch", 32'(fetch_valid), 32'd0);
        check("reload_ready", 32'(ld_ready), 32'd1);
        bytes_q[0] = 8'hAA; bytes_q[1] = 8'hBB; bytes_q[2] = 8'hCC; bytes_q[3] = 8'hDD;
        feed(4, 1'b0, 1'b1);
        fetch("reload_pc0", 32'd0, 32'hDDCC_BBAA, 1'b0, 1'b1);

        // Reset in the middle of a load
        bytes_q[0] = 8'h01; bytes_q[1] = 8'h02; bytes_q[2] = 8'h03;
        start_load(16'd8);
        feed(3, 1'b0, 1'b0);
        fetch_req = 1'b1; pc = 32'd0;
        @(negedge clk);
        fetch_req = 1'b0;
        check("load_nofetch", 32'(fetch_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_ready", 32'(ld_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_req = 1'b1; pc = 32'd0;
        @(negedge clk);
        fetch_req = 1'b0;
        check("halt_nofetch", 32'(fetch_valid), 32'd0);
        start_load(16'd0);
        fetch("midrst_pc0", 32'd0, 32'hDD03_0201, 1'b0, 1'b1);

        // Wrap on the 8-byte instance: bytes 8..11 overwrite 0..3
        b_ld_start = 1'b1; b_ld_len = 16'd12;
        @(negedge clk);
        b_ld_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b_ld_valid = 1'b1;
            b_ld_data  = 8'(8'h10 + i);
            @(negedge clk);
        end
        b_ld_valid = 1'b0;
        check("wrap_done", 32'(b_ld_done), 32'd1);
        b_fetch_req = 1'b1; b_pc = 32'd0;
        @(negedge clk);
        b_pc = 32'd4;
        check("wrap_pc0", b_inst, 32'h1B1A_1918);
        @(negedge clk);
        b_pc = 32'd8;
        check("wrap_pc4", b_inst, 32'h1716_1514);
        check("wrap_pc4_err", 32'(b_fetch_err), 32'd0);
        @(negedge clk);
        b_fetch_req = 1'b0;
        check("wrap_pc8_err", 32'(b_fetch_err), 32'd1);
        check("wrap_pc8_inst", b_inst, NOP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_BYTES, default 256, instruction memory size in bytes; power of two, at least 8.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction word returned on a faulting fetch.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ld_start_i  in  1  single-cycle pulse that starts a boot load.
REQ-006 ld_len_i  in  16  byte count of the load, sampled together with ld_start_i.
REQ-007 ld_valid_i  in  1  load byte valid.
REQ-008 ld_data_i  in  8  load byte.
REQ-009 ld_ready_o  out  1  loader accepts a byte this cycle.
REQ-010 ld_done_o  out  1  one-cycle pulse when the load completes.
REQ-011 fetch_req_i  in  1  fetch request.
REQ-012 pc_i  in  InstAddrBus  fetch byte address.
REQ-013 fetch_valid_o  out  1  inst_o valid.
REQ-014 inst_o  out  InstBus  fetched instruction, little-endian.
REQ-015 fetch_err_o  out  1  fetch fault, qualified by fetch_valid_o.
REQ-016 busy_o  out  1  high in S_HALT and S_LOAD; the core stalls fetch while this is high.

Function
REQ-017 The FSM SHALL have the states S_HALT, S_LOAD and S_RUN.
REQ-018 S_HALT: ld_start_i with ld_len_i != 0 -> S_LOAD, byte counter cleared to 0; ld_start_i with ld_len_i == 0 -> S_RUN, with a ld_done_o pulse on the next cycle.
REQ-019 S_LOAD: ld_ready_o = 1; each cycle with ld_valid_i && ld_ready_o writes ld_data_i to byte address counter mod DEPTH_BYTES, then increments the counter.
REQ-020 The accept of byte number ld_len_i-1 SHALL move the FSM to S_RUN and pulse ld_done_o in the following cycle.
REQ-021 Bytes at counter >= DEPTH_BYTES SHALL wrap around and overwrite from address 0 upward.
REQ-022 ld_start_i in S_LOAD SHALL be ignored.
REQ-023 ld_start_i in S_RUN SHALL restart the load (rule of REQ-018); it has priority over fetch_req_i in the same cycle, and that request is dropped.
REQ-024 ld_ready_o SHALL be 0 outside S_LOAD.
REQ-025 S_RUN: fetch_req_i is accepted every cycle (no back-pressure).
REQ-026 Fetch latency SHALL be 1 cycle: fetch_valid_o = 1 in the cycle after acceptance, with inst_o = {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]} as sampled at acceptance.
REQ-027 A fetch with pc_i[1:0] != 0, or with pc_i > DEPTH_BYTES-4, SHALL return fetch_err_o = 1 and inst_o = NOP_INST.
REQ-028 fetch_req_i in S_HALT or S_LOAD SHALL produce no response (fetch_valid_o = 0).
REQ-029 If fetch_valid_o = 0, inst_o SHALL equal NOP_INST and fetch_err_o SHALL be 0.
REQ-030 Back-to-back requests SHALL return back-to-back responses in request order.

Reset
REQ-031 On rst_n low: state S_HALT, counter 0, ld_ready_o 0, ld_done_o 0, fetch_valid_o 0, fetch_err_o 0, inst_o NOP_INST, busy_o 1.
REQ-032 Memory contents SHALL NOT be reset; they survive reset.
REQ-033 Reset during S_LOAD SHALL abort the load, and bytes already written SHALL remain.
REQ-034 Reset deassertion SHALL be synchronised by the integrating top level; the block itself does not synchronise rst_n.

Structure
REQ-035 InstAddrBus, InstBus and the state enum type imem_state_e SHALL be placed in type_pkg.
REQ-036 The default NOP encoding SHALL be a defines.sv constant.
REQ-037 One sub-module, imem_bram: byte-wide write port plus 32-bit synchronous read port, parametrised by DEPTH_BYTES.

Verification
REQ-038 Load: reset, ld_start with len=8, bytes 13 00 00 00 93 00 F0 00 -> ld_done pulse; fetch pc=0 -> 0x00000013; fetch pc=4 -> 0x00F00093, each 1 cycle after the request.
REQ-039 Misalignment: in S_RUN, fetch pc=2 -> fetch_valid=1, fetch_err=1, inst=0x00000013; fetch pc=DEPTH_BYTES-4 -> fetch_err=0.
REQ-040 Back-pressure: drive ld_valid with gaps (1,0,0,1 pattern) -> exactly ld_len bytes written; busy_o falls only after the final byte is accepted.
REQ-041 Reload vs fetch: ld_start and fetch_req in the same S_RUN cycle -> no fetch_valid, ld_ready=1 next cycle; reload of 4 bytes AA BB CC DD -> pc=0 returns 0xDDCCBBAA.
REQ-042 Reset mid-load: assert rst_n low after 3 of 8 bytes -> S_HALT, busy_o=1, fetch ignored; after a new len=0 load, pc=0 returns the 3 bytes from before the reset plus the old byte 3.
REQ-043 Wrap: DEPTH_BYTES=8, len=12 -> bytes 8..11 overwrite addresses 0..3.
